tsense_seq: RTL and testbench
=============================

# tsense_seq

Parametrised phase sequencer for the switched-capacitor temperature-sensor front end. It runs precharge, a comparator-driven bias-trim loop and NCYC-cycle incremental charge-balancing conversions over NCH diode channels in round-robin. It drives the analog phase switches, comparator strobe and channel select, and returns a per-conversion count with a valid pulse. It sits between the analog macro and the digital readout, under start/recal control.

## Interface
- NCH, 4: diode channels; chan_sel is one-hot.
- NCYC, 64: charge-balancing cycles per conversion.
- PRECHG_CYC, 21: precharge length in clocks.
- BIG_CYC, 8: big-diode (phi1) phase length.
- DIODE_CYC, 8: diode (phi2) phase length.
- CHG_CYC, 5: charge phase length.
- SETUP_STEPS, 7: trim steps per calibration.
- TRIM_W, 6: trim code width.
- GAP_CYC, 1: non-overlap gap length. Used only with TSENSE_NONOVL_EN.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  conversion request, sampled in IDLE only.
- recal  in  1  calibration request, latched at any time.
- cmp  in  1  comparator decision.
- phi1  out  1  big-diode phase switch.
- phi2  out  1  diode phase switch.
- big_en  out  1  large-current diode enable, coincident with phi1.
- sw  out  4  charge switches: bit0 PA, bit1 PB, bit2 PC, bit3 PD.
- prechg  out  1  precharge enable.
- cmp_strobe  out  1  comparator latch strobe.
- chan_sel  out  NCH  one-hot active channel.
- trim  out  TRIM_W  bias trim code.
- busy  out  1  sequencer not in IDLE.
- valid  out  1  one-cycle result strobe.
- result  out  $clog2(NCYC+1)  count of cmp=1 decisions.

## Operation
- States: PRECHG, SETUP_BIG, SETUP_DIO, IDLE, BIG, DIO, HCHG, LCHG, DONE.
- Reset: all outputs 0 except chan_sel=1 (channel 0) and trim=2^(TRIM_W-1).
  - After release the FSM enters PRECHG: prechg=1, sw=4'b1110, busy=1, for PRECHG_CYC clocks.
  - It then runs calibration and goes to IDLE.
- Calibration step: SETUP_BIG (phi1, big_en) for BIG_CYC clocks, then SETUP_DIO (phi2) for DIODE_CYC clocks.
  - cmp_strobe is high in the last SETUP_DIO cycle; cmp is captured at the edge ending that cycle.
  - cmp=1 → trim−1; cmp=0 → trim+1. trim saturates at 0 and 2^TRIM_W−1.
  - SETUP_STEPS steps per calibration.
- IDLE: all switches 0, busy=0.
  - A pending recal takes priority: SETUP runs (no precharge). A start seen on the same clock is held pending and starts after calibration.
  - Otherwise start=1 → BIG on the next clock.
- Conversion cycle: BIG (phi1, big_en, BIG_CYC clocks) → DIO (phi2, DIODE_CYC clocks, cmp_strobe in last cycle).
  - Then HCHG (sw=4'b0011) if the captured cmp=1, else LCHG (sw=4'b0101), for CHG_CYC clocks.
  - Each HCHG increments the result counter (cleared when the conversion starts).
  - After NCYC cycles → DONE.
- DONE: one clock. valid=1, result updated and then held until the next DONE. chan_sel rotates left, wrapping NCH−1→0. Next state is IDLE.
- start while busy is ignored, not queued. recal while busy is latched and serviced at IDLE entry.
- Asynchronous reset mid-operation aborts everything: trim returns to mid-code and the full power-up sequence reruns.

## Timing
- All outputs are registered and change only on clk rising edges.
- Without the macro, phase outputs switch on the same edge as the state change.
- Conversion latency: start edge to valid = NCYC·(BIG_CYC+DIODE_CYC+CHG_CYC)+1 clocks. Defaults: 1345.
- Power-up to IDLE: PRECHG_CYC + SETUP_STEPS·(BIG_CYC+DIODE_CYC) clocks. Defaults: 133.
- The phase counter is a down-counter loaded with length−1. Its terminal flag advances the FSM. All lengths must be ≥1.

## Configuration
- TSENSE_NONOVL_EN defined: GAP_CYC clocks with phi1=phi2=big_en=0 and sw=0 are inserted at every BIG→DIO, DIO→charge and charge→BIG boundary, including the calibration steps.
  - Each conversion cycle is then 3·GAP_CYC clocks longer; each calibration step is 2·GAP_CYC clocks longer.
  - cmp capture timing is unchanged.
- Undefined: no gaps. Phases abut.

## Structure
- Package tsense_pkg: state enum, sw pattern constants (SW_PRECHG, SW_HCHG, SW_LCHG, SW_OFF) and the trim mid-code function.
- Sub-module tsense_phase_timer: loadable down-counter with a last-cycle flag, shared by all phases.

## Test plan
- Reset release, cmp=0 held: prechg=1 for 21 clocks, 7 strobes, then trim=39 and busy falls at clock 133.
- TRIM_W=3, cmp=0 held: trim goes 4→7 and stays at 7 (saturation); cmp=1 held: trim reaches 0 and stays at 0.
- start with cmp=1 held: result=64, valid high for exactly 1 clock, 1345 clocks after start; sw=4'b0011 in every charge phase.
- cmp alternating 1/0: result=32; chan_sel goes 0001→0010, and returns to 0001 after 4 conversions.
- start pulsed while busy: no effect. recal mid-conversion: calibration runs after valid, then IDLE.
- reset asserted during HCHG: outputs clear immediately, trim=32, and the precharge sequence restarts. With TSENSE_NONOVL_EN, phi1 and phi2 are never high together and a gap exists at every boundary.

Source files
------------

// File: rtl/tsense_pkg.sv
// Shared definitions for the temperature-sensor phase sequencer.
//   - FSM state encoding (state_t plus ST_* constants)
//   - charge-switch patterns for the sw[3:0] bus (bit0 PA .. bit3 PD)
//   - phase-timer width and the trim mid-code helper
package tsense_pkg;

  localparam int ST_W  = 4;
  localparam int TMR_W = 16;

  typedef logic [ST_W-1:0] state_t;

  // ST_RST only exists while reset is held; the first clock after
  // release moves to PRECHG so the full precharge length is visible.
  localparam state_t ST_RST       = 4'd0;
  localparam state_t ST_PRECHG    = 4'd1;
  localparam state_t ST_SETUP_BIG = 4'd2;
  localparam state_t ST_SETUP_DIO = 4'd3;
  localparam state_t ST_IDLE      = 4'd4;
  localparam state_t ST_BIG       = 4'd5;
  localparam state_t ST_DIO       = 4'd6;
  localparam state_t ST_HCHG      = 4'd7;
  localparam state_t ST_LCHG      = 4'd8;
  localparam state_t ST_DONE      = 4'd9;
  localparam state_t ST_GAP       = 4'd10;

  localparam logic [3:0] SW_PRECHG = 4'b1110;
  localparam logic [3:0] SW_HCHG   = 4'b0011;
  localparam logic [3:0] SW_LCHG   = 4'b0101;
  localparam logic [3:0] SW_OFF    = 4'b0000;

  // Mid-scale trim code for a w-bit trim DAC.
  function automatic int trim_mid(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/tsense_phase_timer.sv
// Loadable down-counter that times every sequencer phase.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         load load_val (phase length - 1) on this edge
//   load_val     value to load
//   last         counter is 0: current cycle is the last of the phase
//   last_nxt     counter will be 0 after this edge (for registered strobes)
module tsense_phase_timer
  import tsense_pkg::*;
#(
  parameter int CNT_W = TMR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last,
  output logic             last_nxt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last     = (cnt_q == '0);
  assign last_nxt = (cnt_d == '0);

endmodule

// File: rtl/tsense_seq.sv
// Phase sequencer for the switched-capacitor temperature-sensor front end.
// Runs precharge and a bias-trim calibration after reset, then on each
// start performs NCYC charge-balancing cycles on the selected diode
// channel and reports the number of cmp=1 decisions.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 conversion request (honoured in IDLE only)
//   recal                 calibration request (latched at any time)
//   cmp                   comparator decision
//   phi1, big_en, phi2    diode phase switches / big-current enable
//   sw[3:0]               charge switches PA..PD
//   prechg, cmp_strobe    precharge enable, comparator latch strobe
//   chan_sel[NCH-1:0]     one-hot active channel
//   trim[TRIM_W-1:0]      bias trim code
//   busy, valid, result   status, result strobe, result count
// Build option: define TSENSE_NONOVL_EN to insert GAP_CYC all-off clocks
// between adjacent diode / charge phases.
module tsense_seq
  import tsense_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int NCYC        = 64,
  parameter int PRECHG_CYC  = 21,
  parameter int BIG_CYC     = 8,
  parameter int DIODE_CYC   = 8,
  parameter int CHG_CYC     = 5,
  parameter int SETUP_STEPS = 7,
  parameter int TRIM_W      = 6,
  parameter int GAP_CYC     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      recal,
  input  logic                      cmp,
  output logic                      phi1,
  output logic                      phi2,
  output logic                      big_en,
  output logic [3:0]                sw,
  output logic                      prechg,
  output logic                      cmp_strobe,
  output logic [NCH-1:0]            chan_sel,
  output logic [TRIM_W-1:0]         trim,
  output logic                      busy,
  output logic                      valid,
  output logic [$clog2(NCYC+1)-1:0] result
);

  localparam int RES_W  = $clog2(NCYC + 1);
  localparam int STEP_W = $clog2(SETUP_STEPS + 1);
  localparam logic [TRIM_W-1:0] TRIM_MID = TRIM_W'(trim_mid(TRIM_W));

  state_t              state_q, state_d, tgt;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [RES_W-1:0]    cyc_q, cyc_d, hits_q, hits_d, result_q, result_d;
  logic [TRIM_W-1:0]   trim_q, trim_d;
  logic [NCH-1:0]      chan_q, chan_d;
  logic                recal_pend_q, recal_pend_d;
  logic                start_pend_q, start_pend_d;
  logic                go;
  logic                tmr_load, tmr_last, tmr_last_nxt;
  logic [TMR_W-1:0]    tmr_val;

  logic                phi1_q, phi1_d, phi2_q, phi2_d, big_en_q, big_en_d;
  logic                prechg_q, prechg_d, strobe_q, strobe_d;
  logic                busy_q, busy_d, valid_q, valid_d;
  logic [3:0]          sw_q, sw_d;

`ifdef TSENSE_NONOVL_EN
  state_t              ret_q, ret_d;

  // Leaving any switch-driving phase goes through an all-off gap.
  function automatic logic is_phase(input state_t s);
    return (s == ST_SETUP_BIG) || (s == ST_SETUP_DIO) || (s == ST_BIG) ||
           (s == ST_DIO) || (s == ST_HCHG) || (s == ST_LCHG);
  endfunction
`endif

  // Timer reload value (length - 1) for the phase being entered.
  function automatic logic [TMR_W-1:0] phase_len(input state_t s);
    int n;
    case (s)
      ST_PRECHG:              n = PRECHG_CYC;
      ST_SETUP_BIG, ST_BIG:   n = BIG_CYC;
      ST_SETUP_DIO, ST_DIO:   n = DIODE_CYC;
      ST_HCHG, ST_LCHG:       n = CHG_CYC;
      ST_GAP:                 n = GAP_CYC;
      default:                n = 1;
    endcase
    return TMR_W'(n - 1);
  endfunction

  // One trim step: cmp=1 means bias too high, step down; saturating.
  function automatic logic [TRIM_W-1:0] trim_step(input logic [TRIM_W-1:0] t,
                                                   input logic dn);
    if (dn) return (t == '0) ? t : t - 1'b1;
    return (t == '1) ? t : t + 1'b1;
  endfunction

  tsense_phase_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last),
    .last_nxt (tmr_last_nxt)
  );

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cyc_d        = cyc_q;
    hits_d       = hits_q;
    result_d     = result_q;
    trim_d       = trim_q;
    chan_d       = chan_q;
    recal_pend_d = recal_pend_q | recal;
    start_pend_d = start_pend_q;
    go           = 1'b0;
    tgt          = state_q;
`ifdef TSENSE_NONOVL_EN
    ret_d        = ret_q;
`endif

    case (state_q)
      ST_RST: begin
        go  = 1'b1;
        tgt = ST_PRECHG;
      end
      ST_PRECHG: if (tmr_last) begin
        go     = 1'b1;
        tgt    = ST_SETUP_BIG;
        step_d = '0;
      end
      ST_SETUP_BIG: if (tmr_last) begin
        go  = 1'b1;
        tgt = ST_SETUP_DIO;
      end
      ST_SETUP_DIO: if (tmr_last) begin
        go     = 1'b1;
        trim_d = trim_step(trim_q, cmp);
        if (step_q == STEP_W'(SETUP_STEPS - 1)) begin
          tgt = ST_IDLE;
        end else begin
          tgt    = ST_SETUP_BIG;
          step_d = step_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // Recal wins; a coincident start is parked until calibration ends.
        if (recal_pend_q | recal) begin
          go           = 1'b1;
          tgt          = ST_SETUP_BIG;
          step_d       = '0;
          recal_pend_d = 1'b0;
          start_pend_d = start_pend_q | start;
        end else if (start | start_pend_q) begin
          go           = 1'b1;
          tgt          = ST_BIG;
          cyc_d        = '0;
          hits_d       = '0;
          start_pend_d = 1'b0;
        end
      end
      ST_BIG: if (tmr_last) begin
        go  = 1'b1;
        tgt = ST_DIO;
      end
      ST_DIO: if (tmr_last) begin
        go  = 1'b1;
        tgt = cmp ? ST_HCHG : ST_LCHG;
      end
      ST_HCHG, ST_LCHG: if (tmr_last) begin
        go = 1'b1;
        if (cyc_q == RES_W'(NCYC - 1)) begin
          tgt = ST_DONE;
        end else begin
          tgt   = ST_BIG;
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DONE: begin
        go  = 1'b1;
        tgt = ST_IDLE;
      end
`ifdef TSENSE_NONOVL_EN
      ST_GAP: if (tmr_last) begin
        go  = 1'b1;
        tgt = ret_q;
      end
`endif
      default: begin
        go  = 1'b1;
        tgt = ST_IDLE;
      end
    endcase

    tmr_load = go;
    tmr_val  = phase_len(tgt);
    if (go) begin
`ifdef TSENSE_NONOVL_EN
      if (is_phase(state_q)) begin
        state_d = ST_GAP;
        ret_d   = tgt;
        tmr_val = phase_len(ST_GAP);
      end else begin
        state_d = tgt;
      end
`else
      state_d = tgt;
`endif
    end

    // Count on entry to HCHG so each charge phase adds exactly one.
    if (state_d == ST_HCHG && state_q != ST_HCHG)
      hits_d = hits_q + 1'b1;

    if (state_d == ST_DONE && state_q != ST_DONE) begin
      result_d = hits_q;
      chan_d   = {chan_q[NCH-2:0], chan_q[NCH-1]};
    end
  end

  // Outputs are decoded from the next state so they switch on the same
  // edge as the state; the strobe marks the final cycle of a diode phase.
  always_comb begin
    phi1_d   = (state_d == ST_BIG) || (state_d == ST_SETUP_BIG);
    big_en_d = phi1_d;
    phi2_d   = (state_d == ST_DIO) || (state_d == ST_SETUP_DIO);
    strobe_d = phi2_d && tmr_last_nxt;
    prechg_d = (state_d == ST_PRECHG);
    busy_d   = (state_d != ST_IDLE);
    valid_d  = (state_d == ST_DONE);
    case (state_d)
      ST_PRECHG: sw_d = SW_PRECHG;
      ST_HCHG:   sw_d = SW_HCHG;
      ST_LCHG:   sw_d = SW_LCHG;
      default:   sw_d = SW_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RST;
      step_q       <= '0;
      cyc_q        <= '0;
      hits_q       <= '0;
      result_q     <= '0;
      trim_q       <= TRIM_MID;
      chan_q       <= NCH'(1);
      recal_pend_q <= 1'b0;
      start_pend_q <= 1'b0;
      phi1_q       <= 1'b0;
      phi2_q       <= 1'b0;
      big_en_q     <= 1'b0;
      prechg_q     <= 1'b0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      sw_q         <= SW_OFF;
`ifdef TSENSE_NONOVL_EN
      ret_q        <= ST_IDLE;
`endif
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cyc_q        <= cyc_d;
      hits_q       <= hits_d;
      result_q     <= result_d;
      trim_q       <= trim_d;
      chan_q       <= chan_d;
      recal_pend_q <= recal_pend_d;
      start_pend_q <= start_pend_d;
      phi1_q       <= phi1_d;
      phi2_q       <= phi2_d;
      big_en_q     <= big_en_d;
      prechg_q     <= prechg_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      sw_q         <= sw_d;
`ifdef TSENSE_NONOVL_EN
      ret_q        <= ret_d;
`endif
    end
  end

  assign phi1       = phi1_q;
  assign phi2       = phi2_q;
  assign big_en     = big_en_q;
  assign sw         = sw_q;
  assign prechg     = prechg_q;
  assign cmp_strobe = strobe_q;
  assign chan_sel   = chan_q;
  assign trim       = trim_q;
  assign busy       = busy_q;
  assign valid      = valid_q;
  assign result     = result_q;

endmodule

// File: tb/tb_tsense_seq.sv
// Directed bench for tsense_seq: power-up sequence, trim saturation
// (TRIM_W=3 instance), a table of conversions, and reset mid-conversion.
module tb_tsense_seq;

  logic clk = 1'b0;
  logic reset, start, recal, cmp;
  logic phi1, phi2, big_en, prechg, cmp_strobe, busy, valid;
  logic [3:0] sw, chan_sel;
  logic [5:0] trim;
  logic [6:0] result;

  logic rst3, cmp3, start3, recal3;
  logic phi1_3, phi2_3, big_en_3, prechg_3, strobe_3, busy_3, valid_3;
  logic [3:0] sw_3, chan_3;
  logic [2:0] trim_3;
  logic [6:0] result_3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tsense_seq dut (
    .clk(clk), .reset(reset), .start(start), .recal(recal), .cmp(cmp),
    .phi1(phi1), .phi2(phi2), .big_en(big_en), .sw(sw), .prechg(prechg),
    .cmp_strobe(cmp_strobe), .chan_sel(chan_sel), .trim(trim), .busy(busy),
    .valid(valid), .result(result)
  );

  tsense_seq #(.TRIM_W(3)) dut3 (
    .clk(clk), .reset(rst3), .start(start3), .recal(recal3), .cmp(cmp3),
    .phi1(phi1_3), .phi2(phi2_3), .big_en(big_en_3), .sw(sw_3), .prechg(prechg_3),
    .cmp_strobe(strobe_3), .chan_sel(chan_3), .trim(trim_3), .busy(busy_3),
    .valid(valid_3), .result(result_3)
  );

  typedef struct {
    int         pat;        // 0: cmp=0, 1: cmp=1, 2: alternate starting with 1
    int         exp_res;
    logic [3:0] exp_chan;
    bit         mid_start;
    bit         mid_recal;
    int         exp_trim;
  } conv_t;

  conv_t tbl [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int p, input int k);
    if (p == 1) return 1'b1;
    if (p == 0) return 1'b0;
    return (k % 2) == 0;
  endfunction

  // Follow the main instance from reset release until busy drops.
  task automatic pwrup(input int exp_trim);
    int pc, sc, bc, swbad;
    bit done;
    pc = 0; sc = 0; bc = 0; swbad = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #1;
      if (prechg) begin
        pc++;
        if (sw !== 4'b1110) swbad++;
      end
      if (cmp_strobe) sc++;
      if (busy) bc++;
      else done = 1;
    end
    chk("pwr_done", int'(done), 1);
    chk("prechg_len", pc, 21);
    chk("prechg_sw", swbad, 0);
    chk("cal_strobes", sc, 7);
    chk("pwr_busy_len", bc, 133);
    chk("pwr_trim", int'(trim), exp_trim);
  endtask

  task automatic run_conv(input conv_t r);
    int cyc, k, swbad, ovl, bc, sc;
    bit got, upd, done;
    logic [3:0] exp_sw;
    cyc = 0; k = 0; swbad = 0; ovl = 0; got = 0; upd = 0; exp_sw = 4'b0000;
    cmp = pat_bit(r.pat, 0);
    start = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      recal = 1'b0;
      if (upd) begin
        cmp = pat_bit(r.pat, k);
        upd = 0;
      end
      cyc++;
      if (r.mid_start && cyc == 100) start = 1'b1;
      if (r.mid_recal && cyc == 200) recal = 1'b1;
      if (phi1 && phi2) ovl++;
      if (sw != 4'b0000 && sw !== exp_sw) swbad++;
      if (cmp_strobe) begin
        exp_sw = pat_bit(r.pat, k) ? 4'b0011 : 4'b0101;
        k++;
        upd = 1;
      end
      if (valid) got = 1;
    end
    chk("valid_seen", int'(got), 1);
    chk("latency", cyc, 1345);
    chk("decisions", k, 64);
    chk("result", int'(result), r.exp_res);
    chk("chan_sel", int'(chan_sel), int'(r.exp_chan));
    chk("charge_sw", swbad, 0);
    chk("phase_overlap", ovl, 0);
    cmp = 1'b0;
    @(posedge clk); #1;
    chk("valid_width", int'(valid), 0);
    chk("idle_after", int'(busy), 0);
    chk("result_hold", int'(result), r.exp_res);
    if (r.mid_recal) begin
      bc = 0; sc = 0; done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
        @(posedge clk); #1;
        if (cmp_strobe) sc++;
        if (busy) bc++;
        else if (bc > 0) done = 1;
      end
      chk("recal_busy_len", bc, 112);
      chk("recal_strobes", sc, 7);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      chk("no_queued_start", int'(busy), 0);
    end
    chk("trim_after", int'(trim), r.exp_trim);
  endtask

  initial begin
    bit found;
    tbl[0] = '{1, 64, 4'b0010, 1'b1, 1'b0, 39};
    tbl[1] = '{0,  0, 4'b0100, 1'b0, 1'b0, 39};
    tbl[2] = '{2, 32, 4'b1000, 1'b0, 1'b1, 46};
    tbl[3] = '{2, 32, 4'b0001, 1'b0, 1'b0, 46};

    reset = 1'b1; rst3 = 1'b1;
    start = 1'b0; recal = 1'b0; cmp = 1'b0;
    start3 = 1'b0; recal3 = 1'b0; cmp3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phi1", int'(phi1), 0);
    chk("rst_phi2", int'(phi2), 0);
    chk("rst_big_en", int'(big_en), 0);
    chk("rst_sw", int'(sw), 0);
    chk("rst_prechg", int'(prechg), 0);
    chk("rst_strobe", int'(cmp_strobe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_chan", int'(chan_sel), 1);
    chk("rst_trim", int'(trim), 32);
    chk("rst_trim3", int'(trim_3), 4);

    reset = 1'b0; rst3 = 1'b0;
    pwrup(39);
    chk("trim3_sat_hi", int'(trim_3), 7);
    chk("busy3_idle", int'(busy_3), 0);

    // Second power-up of the narrow instance with cmp=1 runs alongside
    // the conversion table.
    rst3 = 1'b1; cmp3 = 1'b1;
    #2;
    rst3 = 1'b0;

    for (int i = 0; i < 4; i++) run_conv(tbl[i]);

    chk("trim3_sat_lo", int'(trim_3), 0);
    chk("busy3_idle2", int'(busy_3), 0);

    // Reset asserted during a charge phase.
    cmp = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (sw == 4'b0011) found = 1;
    end
    chk("hchg_seen", int'(found), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_sw", int'(sw), 0);
    chk("mid_rst_phi", int'({phi1, phi2, big_en}), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_trim", int'(trim), 32);
    chk("mid_rst_chan", int'(chan_sel), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    cmp = 1'b0;
    pwrup(39);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
